// File: rtl/axi_poll_pkg.sv
// Shared constants, FSM encoding and helpers for the AXI4-Lite poll master.
package axi_poll_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } poll_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axi_lite_poll_master_if.sv
// AXI4-Lite read channels plus the outgoing valid/ready stream of the poll master.
interface axi_lite_poll_master_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] out_tdata;
  logic          out_tuser;
  logic          out_tvalid;
  logic          out_tready;

  modport master (
    output araddr, arprot, arvalid, rready, out_tdata, out_tuser, out_tvalid,
    input  arready, rdata, rresp, rvalid, out_tready
  );

  modport slave (
    input  araddr, arprot, arvalid, rready, out_tdata, out_tuser, out_tvalid,
    output arready, rdata, rresp, rvalid, out_tready
  );
endinterface

// File: rtl/axi_poll_fifo.sv
// Synchronous FIFO (power-of-two depth) exposing its fill count for slot reservation.
module axi_poll_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full, w_do_push, w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset because the head entry drives the output bus, which must read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/axi_lite_poll_master.sv
// AXI4-Lite read-only master polling one register every POLL_PERIOD cycles into a stream FIFO.
// Define POLL_CHECK_EN to compare OKAY responses against EXPECTED_VALUE and count mismatches.
module axi_lite_poll_master
  import axi_poll_pkg::*;
#(
  parameter int                              C_M00_AXI_DATA_WIDTH = 32,
  parameter int                              C_M00_AXI_ADDR_WIDTH = 4,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] POLL_ADDR            = '0,
  parameter int                              POLL_PERIOD          = 1000,
  parameter int                              FIFO_DEPTH           = 4
`ifdef POLL_CHECK_EN
  ,
  parameter logic [C_M00_AXI_DATA_WIDTH-1:0] EXPECTED_VALUE = C_M00_AXI_DATA_WIDTH'(32'h0012_3456)
`endif
) (
  input  logic                   m00_axi_aclk,
  input  logic                   m00_axi_aresetn,
  input  logic                   poll_en,
  axi_lite_poll_master_if.master m00_axi,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            err_cnt
);
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int TW = $clog2(POLL_PERIOD);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [TW-1:0] r_timer;
  poll_state_t   r_state, w_state_nxt;
  logic [15:0]   r_drop_cnt;
  logic          w_tick, w_slot_free, w_issue, w_drop, w_push, w_pop, w_resp_err;
  logic          w_arvalid, w_rready, w_head_valid;
  logic [CW-1:0] w_fifo_count;
  logic [DW:0]   w_head;

  assign w_tick = poll_en && (r_timer == TW'(POLL_PERIOD - 1));

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_timer <= '0;
    end else if (!poll_en || w_tick) begin
      // NOTE: registers use <= so every flop samples pre-edge values regardless of process order.
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Only one read is ever outstanding, so in IDLE no slot is reserved yet.
  assign w_slot_free = (w_fifo_count < CW'(FIFO_DEPTH));
  assign w_issue     = w_tick && (r_state == IDLE) && w_slot_free;
  assign w_drop      = w_tick && !w_issue;
  assign w_push      = (r_state == DATA) && m00_axi.rvalid;
  assign w_resp_err  = (m00_axi.rresp == RESP_SLVERR) || (m00_axi.rresp == RESP_DECERR);

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) r_state <= IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    unique case (r_state)
      IDLE: if (w_issue) w_state_nxt = ADDR;
      ADDR: begin
        w_arvalid = 1'b1;
        if (m00_axi.arready) w_state_nxt = DATA;
      end
      DATA: begin
        w_rready = 1'b1;
        if (m00_axi.rvalid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign m00_axi.araddr  = POLL_ADDR;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arvalid = w_arvalid;
  assign m00_axi.rready  = w_rready;

  assign w_pop = w_head_valid && m00_axi.out_tready;

  axi_poll_fifo #(.WIDTH(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (m00_axi_aclk),
    .rst_n   (m00_axi_aresetn),
    .i_push  (w_push),
    .i_data  ({w_resp_err, m00_axi.rdata}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_head_valid),
    .o_count (w_fifo_count)
  );

  assign m00_axi.out_tdata  = w_head[DW-1:0];
  assign m00_axi.out_tuser  = w_head[DW];
  assign m00_axi.out_tvalid = w_head_valid;

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) r_drop_cnt <= '0;
    else if (w_drop)      r_drop_cnt <= sat_inc16(r_drop_cnt);
  end

  assign drop_cnt = r_drop_cnt;

`ifdef POLL_CHECK_EN
  logic [15:0] r_err_cnt;
  logic        w_mismatch;

  assign w_mismatch = w_push && (m00_axi.rresp == RESP_OKAY) && (m00_axi.rdata != EXPECTED_VALUE);

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) r_err_cnt <= '0;
    else if (w_mismatch)  r_err_cnt <= sat_inc16(r_err_cnt);
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule
